press_arbiter: RTL and testbench
================================

Name: press_arbiter

Overview:
- Sequences access to a single shared game-logic "move" resource among N player buttons.
- Inputs arrive already conditioned by the 2-flop synch blocks.
- Per input: detects a new press and latches it as a pending request.
- Round-robin grant: issues one one-cycle grant at a time, followed by a fixed cooldown.
- Sits between the synch stages and the playfield/score FSM.

Parameters:
- N, 2, number of requesters (buttons); N >= 2.
- COOLDOWN, 3, cycles after a grant cycle during which no new grant issues; 0 is legal.
- DEBOUNCE, 4, consecutive high cycles required for a press (used only with the optional feature); DEBOUNCE >= 1.

Ports:
- clk  in  1  system clock; the only clock in the block.
- reset  in  1  synchronous, active-high reset.
- key_sync  in  N  synchronized button levels, 1 = pressed.
- grant  out  N  one-hot grant, high for exactly one cycle.
- grant_valid  out  1  high in the same cycle as grant.
- grant_id  out  $clog2(N)  index of the granted requester; valid when grant_valid = 1.
- pending  out  N  latched, not-yet-granted requests.
- busy  out  1  high in GRANT and COOLDOWN states.

Behaviour:
- Reset values: grant = 0, grant_valid = 0, grant_id = 0, pending = 0, busy = 0, state = IDLE, rr_ptr = 0, cooldown counter = 0.
- During reset, prev_key is loaded with key_sync, so a key held through reset produces no press.
- Press event (base): key_sync[i] = 1 and prev_key[i] = 0; prev_key updates every cycle.
  - Holding a key yields exactly one event.
- pending[i] is set on a press event and cleared when i is granted.
  - A press while pending[i] = 1 is absorbed (no counting).
  - Same-cycle set and clear on the same bit: set wins.
- FSM states are IDLE, GRANT and COOLDOWN.
- IDLE:
  - If pending != 0 at the edge: state becomes GRANT.
  - Winner = first set bit of pending searching upward from rr_ptr, wrapping N-1 -> 0.
  - At that edge, register grant = onehot(winner), grant_valid = 1 and grant_id = winner; clear pending[winner]; rr_ptr = (winner+1) mod N.
- GRANT lasts exactly one cycle.
  - If COOLDOWN > 0: go to COOLDOWN and load the counter with COOLDOWN-1.
  - Otherwise go to IDLE.
  - grant and grant_valid drop to 0 at this edge.
- COOLDOWN:
  - Counter decrements each cycle; go to IDLE when it reads 0.
  - Lasts exactly COOLDOWN cycles.
- Press events during GRANT or COOLDOWN still set pending; they are served in the next IDLE.
- Latency: key_sync first sampled high at edge t -> pending visible after t -> grant visible after edge t+1 (2 cycles).
- Grant spacing: minimum COOLDOWN+2 cycles between grant pulses, i.e. GRANT, COOLDOWN x COOLDOWN, then one IDLE cycle.
- Reset mid-operation: all state, pending and outputs return to reset values on the next edge; in-flight requests are dropped.
- No combinational path from key_sync to any output; all outputs are registered.

Optional Feature:
- Macro: PRESS_ARB_DEBOUNCE_EN.
- Defined:
  - Each input has a saturating counter of width $clog2(DEBOUNCE+1).
  - Counter increments while key_sync[i] = 1 and clears when key_sync[i] = 0.
  - The press event fires once, on the cycle the counter reaches DEBOUNCE.
  - Glitches shorter than DEBOUNCE cycles are ignored; latency grows by DEBOUNCE-1 cycles.
  - During reset, the counter of a held key preloads to DEBOUNCE, so there is no press on release of reset.
- Undefined: base edge detect as specified above; the DEBOUNCE parameter is unused.

Decomposition:
- Package press_arb_pkg:
  - typedef enum logic [1:0] {IDLE, GRANT, COOLDOWN} arb_state_t.
  - Default constants for COOLDOWN and DEBOUNCE.
- Sub-module press_edge, instantiated N times:
  - Ports: clk, reset, key, press.
  - Contains prev_key and, under PRESS_ARB_DEBOUNCE_EN, the debounce counter.
- Round-robin pick logic stays in press_arbiter as a combinational function.

Test Plan:
- key_sync = 01 held through reset, then reset = 0 for 10 cycles -> pending stays 00, no grant.
- key_sync[0] rises at edge t -> pending = 01 after t; grant = 01, grant_id = 0, grant_valid = 1 for one cycle after t+1; busy high 4 cycles; pending = 00.
- key_sync 00 -> 11 in one cycle with rr_ptr = 0 -> grant 01 at cycle g; grant 10 at cycle g+5; pending 11 -> 10 -> 00.
- Both keys re-pressed before each grant, over 6 grants -> grant_id sequence 0,1,0,1,0,1.
- key_sync[1] held high 12 cycles -> exactly one grant (10).
- Reset asserted during COOLDOWN with pending = 10 -> next cycle all outputs 0, busy 0; no grant after release.
- With PRESS_ARB_DEBOUNCE_EN and DEBOUNCE = 4: a 3-cycle pulse -> no grant; a 4-cycle pulse -> one grant.

Source files
------------

// File: rtl/press_arb_pkg.sv
// press_arb_pkg: shared types and defaults for the press arbiter.
// Optional build macro: PRESS_ARB_DEBOUNCE_EN (see press_edge).
package press_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    COOLDOWN
  } arb_state_t;

  localparam int unsigned C_COOLDOWN = 3;
  localparam int unsigned C_DEBOUNCE = 4;

endpackage

// File: rtl/press_edge.sv
// press_edge: turns one synchronized key level into a one-cycle press.
// Ports: clk, reset (sync, active-high), key (level), press (event).
// Macro PRESS_ARB_DEBOUNCE_EN: require DEBOUNCE high cycles per press.
module press_edge #(
  parameter int unsigned DEBOUNCE = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic key,
  output logic press
);

`ifdef PRESS_ARB_DEBOUNCE_EN
  localparam int unsigned   DW     = $clog2(DEBOUNCE + 1);
  localparam logic [DW-1:0] DB_MAX = DW'(DEBOUNCE);
  localparam logic [DW-1:0] DB_ARM = DW'(DEBOUNCE - 1);

  logic [DW-1:0] r_cnt;

  // A key held through reset starts saturated, so no press on release.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= key ? DB_MAX : '0;
    end else if (!key) begin
      r_cnt <= '0;
    end else if (r_cnt != DB_MAX) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Fires on the edge where the count reaches DEBOUNCE.
  assign press = key & (r_cnt == DB_ARM);
`else
  logic r_prev;

  // Loaded in reset as well, so a held key yields no press.
  always_ff @(posedge clk) begin
    r_prev <= key;
  end

  assign press = key & ~r_prev;

  // DEBOUNCE only shapes the debounced build.
  if (DEBOUNCE == 0) begin : g_unused_debounce
  end
`endif

endmodule

// File: rtl/press_arbiter.sv
// press_arbiter: round-robin one-shot grants of a shared move resource.
// Ports: clk, reset, key_sync[N] in; grant[N], grant_valid, grant_id,
// pending[N], busy out (all registered).
// Macro PRESS_ARB_DEBOUNCE_EN: debounced press detection in press_edge.
module press_arbiter #(
  parameter int unsigned N        = 2,
  parameter int unsigned COOLDOWN = press_arb_pkg::C_COOLDOWN,
  parameter int unsigned DEBOUNCE = press_arb_pkg::C_DEBOUNCE
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N-1:0]         key_sync,
  output logic [N-1:0]         grant,
  output logic                 grant_valid,
  output logic [$clog2(N)-1:0] grant_id,
  output logic [N-1:0]         pending,
  output logic                 busy
);
  import press_arb_pkg::*;

  localparam int unsigned IW = $clog2(N);
  localparam int unsigned CW =
    (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;
  localparam logic [CW-1:0] CD_LOAD =
    (COOLDOWN > 0) ? CW'(COOLDOWN - 1) : '0;
  localparam logic [N-1:0] ONE = N'(1);

  arb_state_t    r_state;
  logic [N-1:0]  r_grant;
  logic [N-1:0]  r_pending;
  logic          r_gv;
  logic          r_busy;
  logic [IW-1:0] r_gid;
  logic [IW-1:0] r_rr;
  logic [CW-1:0] r_cd;

  logic [N-1:0]  w_press;
  logic [N-1:0]  w_win_oh;
  logic [N-1:0]  w_clr;
  logic [N-1:0]  w_pend_nxt;
  logic [IW-1:0] w_win;
  logic [IW-1:0] w_rr_nxt;
  logic          w_take;

  for (genvar i = 0; i < N; i++) begin : g_edge
    press_edge #(
      .DEBOUNCE(DEBOUNCE)
    ) u_edge (
      .clk  (clk),
      .reset(reset),
      .key  (key_sync[i]),
      .press(w_press[i])
    );
  end

  // First set bit at or above ptr, wrapping past N-1 to 0.
  function automatic logic [IW-1:0] rr_pick(
    input logic [N-1:0]  req,
    input logic [IW-1:0] ptr
  );
    logic [IW-1:0] win;
    logic          found;
    int unsigned   idx;
    win   = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!found && req[idx]) begin
        win   = IW'(idx);
        found = 1'b1;
      end
    end
    return win;
  endfunction

  always_comb begin
    w_win      = rr_pick(r_pending, r_rr);
    w_take     = (r_state == IDLE) && (|r_pending);
    w_win_oh   = ONE << w_win;
    w_clr      = w_take ? w_win_oh : '0;
    // A new press on the granted bit survives the clear.
    w_pend_nxt = (r_pending & ~w_clr) | w_press;
    w_rr_nxt   = (w_win == IW'(N - 1)) ? '0 : w_win + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_grant   <= '0;
      r_gv      <= 1'b0;
      r_gid     <= '0;
      r_pending <= '0;
      r_busy    <= 1'b0;
      r_rr      <= '0;
      r_cd      <= '0;
    end else begin
      r_pending <= w_pend_nxt;
      unique case (r_state)
        IDLE: begin
          if (w_take) begin
            r_state <= GRANT;
            r_grant <= w_win_oh;
            r_gv    <= 1'b1;
            r_gid   <= w_win;
            r_rr    <= w_rr_nxt;
            r_busy  <= 1'b1;
          end
        end
        GRANT: begin
          r_grant <= '0;
          r_gv    <= 1'b0;
          if (COOLDOWN > 0) begin
            r_state <= press_arb_pkg::COOLDOWN;
            r_cd    <= CD_LOAD;
          end else begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end
        press_arb_pkg::COOLDOWN: begin
          if (r_cd == '0) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_cd <= r_cd - 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign grant       = r_grant;
  assign grant_valid = r_gv;
  assign grant_id    = r_gid;
  assign pending     = r_pending;
  assign busy        = r_busy;

endmodule

// File: tb/tb_press_arbiter.sv
// tb_press_arbiter: directed checks of press_arbiter (N=2, COOLDOWN=3).
// Honours PRESS_ARB_DEBOUNCE_EN to exercise the debounced build.
module tb_press_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] key_sync;
  logic [1:0] grant;
  logic       grant_valid;
  logic [0:0] grant_id;
  logic [1:0] pending;
  logic       busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  press_arbiter #(
    .N       (2),
    .COOLDOWN(3),
    .DEBOUNCE(4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .key_sync   (key_sync),
    .grant      (grant),
    .grant_valid(grant_valid),
    .grant_id   (grant_id),
    .pending    (pending),
    .busy       (busy)
  );

  typedef struct {
    int         reps;
    logic       rst;
    logic [1:0] key;
    logic [1:0] g;
    logic       gv;
    logic [0:0] gid;
    logic [1:0] pend;
    logic       bsy;
    string      name;
  } vec_t;

  vec_t tv[$];

  task automatic add(input int reps, input logic rst,
                     input logic [1:0] key, input logic [1:0] g,
                     input logic gv, input logic [0:0] gid,
                     input logic [1:0] pend, input logic bsy,
                     input string name);
    vec_t v;
    v.reps = reps; v.rst = rst; v.key = key;
    v.g = g; v.gv = gv; v.gid = gid;
    v.pend = pend; v.bsy = bsy; v.name = name;
    tv.push_back(v);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string nm, input logic [1:0] g,
                           input logic gv, input logic [0:0] gid,
                           input logic [1:0] p, input logic b);
    checks++;
    if (grant !== g || grant_valid !== gv || grant_id !== gid ||
        pending !== p || busy !== b) begin
      errors++;
      $display("FAIL %s: got g=%b v=%b id=%0d p=%b b=%b want g=%b v=%b id=%0d p=%b b=%b",
               nm, grant, grant_valid, grant_id, pending, busy,
               g, gv, gid, p, b);
    end
  endtask

  task automatic check_int(input string nm, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", nm, got, want);
    end
  endtask

  initial begin
    int n;
    int cyc;
    reset    = 1'b1;
    key_sync = 2'b00;

`ifndef PRESS_ARB_DEBOUNCE_EN
    //  reps rst key   grant v id pend busy
    add(2,  1, 2'b01, 2'b00, 0, 0, 2'b00, 0, "rst_hold");
    add(10, 0, 2'b01, 2'b00, 0, 0, 2'b00, 0, "held_no_press");
    add(1,  0, 2'b00, 2'b00, 0, 0, 2'b00, 0, "release");
    add(1,  0, 2'b01, 2'b00, 0, 0, 2'b01, 0, "press_pend");
    add(1,  0, 2'b01, 2'b01, 1, 0, 2'b00, 1, "grant0");
    add(3,  0, 2'b01, 2'b00, 0, 0, 2'b00, 1, "cooldown");
    add(2,  0, 2'b00, 2'b00, 0, 0, 2'b00, 0, "idle_after");
    add(1,  1, 2'b00, 2'b00, 0, 0, 2'b00, 0, "rst2");
    add(1,  0, 2'b11, 2'b00, 0, 0, 2'b11, 0, "both_pend");
    add(1,  0, 2'b11, 2'b01, 1, 0, 2'b10, 1, "both_g0");
    add(3,  0, 2'b11, 2'b00, 0, 0, 2'b10, 1, "both_cd");
    add(1,  0, 2'b11, 2'b00, 0, 0, 2'b10, 0, "both_idle");
    add(1,  0, 2'b11, 2'b10, 1, 1, 2'b00, 1, "both_g1");
    add(3,  0, 2'b11, 2'b00, 0, 1, 2'b00, 1, "both_cd2");
    add(2,  0, 2'b00, 2'b00, 0, 1, 2'b00, 0, "both_done");
    add(1,  0, 2'b10, 2'b00, 0, 1, 2'b10, 0, "hold1_pend");
    add(1,  0, 2'b10, 2'b10, 1, 1, 2'b00, 1, "hold1_g");
    add(3,  0, 2'b10, 2'b00, 0, 1, 2'b00, 1, "hold1_cd");
    add(7,  0, 2'b10, 2'b00, 0, 1, 2'b00, 0, "hold1_once");
    add(2,  0, 2'b00, 2'b00, 0, 1, 2'b00, 0, "hold1_rel");

    foreach (tv[k]) begin
      for (int r = 0; r < tv[k].reps; r++) begin
        reset    = tv[k].rst;
        key_sync = tv[k].key;
        step();
        check_out(tv[k].name, tv[k].g, tv[k].gv, tv[k].gid,
                  tv[k].pend, tv[k].bsy);
      end
    end

    // Round robin: both keys re-pressed before every grant.
    for (int g = 0; g < 6; g++) begin
      key_sync = 2'b11;
      step();
      key_sync = 2'b00;
      cyc = 1;
      while (!grant_valid && cyc < 20) begin
        step();
        cyc++;
      end
      if (!grant_valid) begin
        checks++;
        errors++;
        $display("FAIL rr_timeout: got no grant want grant %0d", g);
      end else begin
        check_int("rr_id", int'(grant_id), g % 2);
        check_int("rr_onehot", int'(grant), (g % 2) ? 2 : 1);
        check_int("rr_gap", cyc, (g == 0) ? 2 : 5);
      end
    end
    for (int w = 0; w < 20; w++) step();

    // Reset in the middle of a cooldown with a request still pending.
    reset    = 1'b1;
    key_sync = 2'b00;
    step();
    reset    = 1'b0;
    key_sync = 2'b11;
    step();
    check_out("mid_pend", 2'b00, 0, 0, 2'b11, 0);
    step();
    check_out("mid_grant", 2'b01, 1, 0, 2'b10, 1);
    step();
    check_out("mid_cd", 2'b00, 0, 0, 2'b10, 1);
    reset = 1'b1;
    step();
    check_out("mid_rst", 2'b00, 0, 0, 2'b00, 0);
    reset = 1'b0;
    n = 0;
    for (int w = 0; w < 10; w++) begin
      step();
      if (grant_valid || pending != 2'b00) n++;
    end
    check_int("mid_no_grant", n, 0);
    key_sync = 2'b00;
`else
    // Key held through reset: no press on release.
    reset    = 1'b1;
    key_sync = 2'b10;
    step();
    step();
    check_out("db_rst", 2'b00, 0, 0, 2'b00, 0);
    reset = 1'b0;
    n = 0;
    for (int w = 0; w < 10; w++) begin
      step();
      if (grant_valid || pending != 2'b00) n++;
    end
    check_int("db_held_rst", n, 0);
    key_sync = 2'b00;
    step();

    // Three-cycle glitch is ignored.
    key_sync = 2'b01;
    for (int w = 0; w < 3; w++) step();
    check_out("db_glitch_p", 2'b00, 0, 0, 2'b00, 0);
    key_sync = 2'b00;
    n = 0;
    for (int w = 0; w < 15; w++) begin
      step();
      if (grant_valid || pending != 2'b00) n++;
    end
    check_int("db_glitch", n, 0);

    // Four-cycle pulse gives one grant.
    key_sync = 2'b01;
    for (int w = 0; w < 4; w++) step();
    check_out("db_press", 2'b00, 0, 0, 2'b01, 0);
    key_sync = 2'b00;
    n = 0;
    for (int w = 0; w < 20; w++) begin
      step();
      if (grant_valid) n++;
    end
    check_int("db_one_grant", n, 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
